// File: rtl/cpu_mem_bridge_pkg.sv
// cpu_mem_bridge_pkg: shared addresses, LFSR taps and step function for the CPU/VGA/RAM bridge
package cpu_mem_bridge_pkg;
  localparam logic [15:0] RND_ADDR_DEF = 16'h00FE;
  localparam logic [15:0] KEY_ADDR_DEF = 16'h00FF;
  localparam logic [15:0] SCREEN_BASE = 16'h0200;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/cpu_mem_bridge_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11), reloads SEED on reset
module lfsr16
  import cpu_mem_bridge_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);
  logic [15:0] q_q, q_d;
  always_comb q_d = lfsr_next(q_q);
  always_ff @(posedge clk) q_q <= reset ? SEED : q_d;
  assign q = q_q;
endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: VGA-priority RAM arbiter with CPU read hold and easy6502 random/key I/O bytes
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] RND_ADDR   = RND_ADDR_DEF,
  parameter logic [15:0] KEY_ADDR   = KEY_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           cpu_addr,
  input  logic [7:0]            cpu_do,
  input  logic                  cpu_we,
  output logic [7:0]            cpu_di,
  output logic                  cpu_rdy,
  input  logic                  vga_read_en,
  input  logic [ADDR_WIDTH-1:0] vga_read_addr,
  output logic [7:0]            vga_read_data,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout
);
  logic [15:0] lfsr;
  logic [7:0] lfsr_hi_unused;
  logic grant, io_hit;
  logic cpu_fetch_q, cpu_fetch_d, io_fetch_q, io_fetch_d;
  logic [7:0] io_val_q, io_val_d, di_hold_q, di_hold_d, key_q, key_d;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .q(lfsr));
  assign lfsr_hi_unused = lfsr[15:8];
  always_comb begin
    grant = !reset && !vga_read_en;
    io_hit = cpu_addr == RND_ADDR || cpu_addr == KEY_ADDR;
    cpu_rdy = grant;
    ram_addr = vga_read_en ? vga_read_addr : cpu_addr[ADDR_WIDTH-1:0];
    ram_we = cpu_we && grant && !io_hit;
    ram_din = cpu_do;
    vga_read_data = ram_dout;
    cpu_di = cpu_fetch_q ? (io_fetch_q ? io_val_q : ram_dout) : di_hold_q;
    cpu_fetch_d = grant && !cpu_we;
    io_fetch_d = grant && io_hit;
    io_val_d = cpu_addr == RND_ADDR ? lfsr[7:0] : key_q;
    di_hold_d = cpu_di;
    key_d = key_valid ? key_code : (grant && cpu_we && cpu_addr == KEY_ADDR) ? cpu_do : key_q;
  end
  always_ff @(posedge clk) begin
    cpu_fetch_q <= reset ? 1'b0 : cpu_fetch_d;
    io_fetch_q <= reset ? 1'b0 : io_fetch_d;
    io_val_q <= reset ? 8'h00 : io_val_d;
    di_hold_q <= reset ? 8'h00 : di_hold_d;
    key_q <= reset ? 8'h00 : key_d;
  end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge: table-driven and sequence checks of arbitration, read hold and I/O bytes
module tb_cpu_mem_bridge;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_do = '0, key_code = '0, cpu_di, vga_read_data, ram_din, ram_dout;
  logic cpu_we = 1'b0, vga_read_en = 1'b0, key_valid = 1'b0, cpu_rdy, ram_we;
  logic [10:0] vga_read_addr = '0, ram_addr;
  logic [7:0] mem [0:2047];
  logic [15:0] model_lfsr;
  logic [7:0] rnd_exp [2];
  int total = 0, bad = 0;

  typedef struct {
    logic [15:0] a; logic [7:0] d; logic we; logic v; logic [10:0] va; logic kv; logic [7:0] kc;
    logic rdy; logic rwe; logic [10:0] ra; logic [7:0] di; logic cv; logic [7:0] vd;
  } vec_t;
  vec_t t [25];

  cpu_mem_bridge dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .vga_read_en(vga_read_en), .vga_read_addr(vga_read_addr),
    .vga_read_data(vga_read_data), .key_valid(key_valid), .key_code(key_code),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
      mem[11'h010] <= 8'h5A;
      mem[11'h200] <= 8'h07;
      mem[11'h7FE] <= 8'hC3;
      mem[11'h0FF] <= 8'h99;
      mem[11'h0FE] <= 8'h88;
    end else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) model_lfsr <= reset ? 16'hACE1 : ({1'b0, model_lfsr[15:1]} ^ (model_lfsr[0] ? 16'hB400 : 16'h0000));

  function automatic vec_t mk(logic [15:0] a, logic [7:0] d, logic we, logic v, logic [10:0] va,
                              logic kv, logic [7:0] kc, logic rdy, logic rwe, logic [10:0] ra,
                              logic [7:0] di, logic cv, logic [7:0] vd);
    vec_t r;
    r.a = a; r.d = d; r.we = we; r.v = v; r.va = va; r.kv = kv; r.kc = kc;
    r.rdy = rdy; r.rwe = rwe; r.ra = ra; r.di = di; r.cv = cv; r.vd = vd;
    return r;
  endfunction

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we, input logic v, input logic [10:0] va);
    cpu_addr = a; cpu_do = d; cpu_we = we; vga_read_en = v; vga_read_addr = va;
  endtask

  initial begin
    t[0]  = mk(16'h0010, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h010, 8'h00, 0, 8'h00);
    t[1]  = mk(16'h0010, 8'h00, 0, 1, 11'h200, 0, 8'h00, 0, 0, 11'h200, 8'h5A, 1, 8'h5A);
    t[2]  = mk(16'h0010, 8'h00, 0, 1, 11'h200, 0, 8'h00, 0, 0, 11'h200, 8'h5A, 0, 8'h00);
    t[3]  = mk(16'h0600, 8'h33, 1, 1, 11'h200, 0, 8'h00, 0, 0, 11'h200, 8'h5A, 0, 8'h00);
    t[4]  = mk(16'h0600, 8'h33, 1, 1, 11'h200, 0, 8'h00, 0, 0, 11'h200, 8'h5A, 0, 8'h00);
    t[5]  = mk(16'h0600, 8'h33, 1, 1, 11'h200, 0, 8'h00, 0, 0, 11'h200, 8'h5A, 0, 8'h00);
    t[6]  = mk(16'h0600, 8'h33, 1, 0, 11'h000, 0, 8'h00, 1, 1, 11'h600, 8'h5A, 0, 8'h00);
    t[7]  = mk(16'h0600, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h600, 8'h5A, 0, 8'h00);
    t[8]  = mk(16'h0010, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h010, 8'h33, 0, 8'h00);
    t[9]  = mk(16'h0010, 8'h00, 0, 1, 11'h200, 0, 8'h00, 0, 0, 11'h200, 8'h5A, 0, 8'h00);
    t[10] = mk(16'h0600, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h600, 8'h5A, 1, 8'h07);
    t[11] = mk(16'h0000, 8'h00, 0, 0, 11'h000, 1, 8'h77, 1, 0, 11'h000, 8'h33, 0, 8'h00);
    t[12] = mk(16'h00FF, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h0FF, 8'h00, 0, 8'h00);
    t[13] = mk(16'h00FF, 8'h00, 1, 0, 11'h000, 0, 8'h00, 1, 0, 11'h0FF, 8'h77, 0, 8'h00);
    t[14] = mk(16'h00FF, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h0FF, 8'h77, 0, 8'h00);
    t[15] = mk(16'h00FF, 8'h00, 1, 0, 11'h000, 1, 8'h41, 1, 0, 11'h0FF, 8'h00, 0, 8'h00);
    t[16] = mk(16'h00FF, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h0FF, 8'h00, 0, 8'h00);
    t[17] = mk(16'h00FF, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h0FF, 8'h41, 0, 8'h00);
    t[18] = mk(16'h08FF, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h0FF, 8'h41, 0, 8'h00);
    t[19] = mk(16'hFFFE, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h7FE, 8'h99, 0, 8'h00);
    t[20] = mk(16'h0000, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h000, 8'hC3, 0, 8'h00);
    t[21] = mk(16'h00FE, 8'hEE, 1, 0, 11'h000, 0, 8'h00, 1, 0, 11'h0FE, 8'h00, 0, 8'h00);
    t[22] = mk(16'h08FE, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h0FE, 8'h00, 0, 8'h00);
    t[23] = mk(16'h0000, 8'h00, 0, 0, 11'h000, 0, 8'h00, 1, 0, 11'h000, 8'h88, 0, 8'h00);
    t[24] = mk(16'hFFFF, 8'h12, 1, 0, 11'h000, 0, 8'h00, 1, 1, 11'h7FF, 8'h00, 0, 8'h00);

    load = 1'b1;
    drive(16'h0600, 8'hAB, 1, 0, 11'h000);
    step();
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_rdy", 16'(cpu_rdy), 16'h0);
      chk("reset_we", 16'(ram_we), 16'h0);
      step();
    end
    reset = 1'b0;
    chk("reset_lfsr", dut.lfsr, 16'hACE1);

    for (int i = 0; i < 25; i++) begin
      drive(t[i].a, t[i].d, t[i].we, t[i].v, t[i].va);
      key_valid = t[i].kv; key_code = t[i].kc;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 16'(cpu_rdy), 16'(t[i].rdy));
      chk($sformatf("v%0d_we", i), 16'(ram_we), 16'(t[i].rwe));
      chk($sformatf("v%0d_addr", i), 16'(ram_addr), 16'(t[i].ra));
      chk($sformatf("v%0d_di", i), 16'(cpu_di), 16'(t[i].di));
      if (t[i].cv) chk($sformatf("v%0d_vdata", i), 16'(vga_read_data), 16'(t[i].vd));
      step();
    end
    key_valid = 1'b0;
    chk("ram_0ff_kept", 16'(mem[11'h0FF]), 16'h0099);
    chk("ram_0fe_kept", 16'(mem[11'h0FE]), 16'h0088);
    chk("ram_7ff_written", 16'(mem[11'h7FF]), 16'h0012);

    reset = 1'b1;
    drive(16'h0000, 8'h00, 0, 0, 11'h000);
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive((c == 5 || c == 6) ? 16'h00FE : 16'h0000, 8'h00, 0, 0, 11'h000);
      @(negedge clk);
      chk($sformatf("lfsr_c%0d", c), dut.lfsr, model_lfsr);
      if (c == 5 || c == 6) rnd_exp[c - 5] = model_lfsr[7:0];
      if (c == 6) chk("rnd_c5", 16'(cpu_di), 16'(rnd_exp[0]));
      if (c == 7) chk("rnd_c6", 16'(cpu_di), 16'(rnd_exp[1]));
      step();
    end

    drive(16'h0010, 8'h00, 0, 0, 11'h000);
    step();
    drive(16'h0010, 8'h00, 0, 1, 11'h200);
    @(negedge clk);
    chk("stall_di", 16'(cpu_di), 16'h005A);
    chk("stall_rdy", 16'(cpu_rdy), 16'h0);
    step();
    reset = 1'b1;
    drive(16'h0600, 8'hAB, 1, 1, 11'h200);
    @(negedge clk);
    chk("rst_stall_rdy", 16'(cpu_rdy), 16'h0);
    chk("rst_stall_we", 16'(ram_we), 16'h0);
    step();
    vga_read_en = 1'b0;
    @(negedge clk);
    chk("rst_novga_rdy", 16'(cpu_rdy), 16'h0);
    chk("rst_novga_we", 16'(ram_we), 16'h0);
    step();
    reset = 1'b0;
    drive(16'h0000, 8'h00, 0, 0, 11'h000);
    @(negedge clk);
    chk("post_rst_di", 16'(cpu_di), 16'h0000);
    chk("post_rst_lfsr", dut.lfsr, 16'hACE1);
    chk("ram_600_kept", 16'(mem[11'h600]), 16'h0033);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
